lcd_counter_roi: RTL and testbench
==================================

LCD_COUNTER_ROI -- requirements
Module: lcd_counter_roi

Interface
REQ-001 Parameter CW, default 12, width of counters, lengths and window coordinates.
REQ-002 Parameter NW, default 2, number of independent overlay windows.
REQ-003 Parameter BORDER, default 1, overlay line thickness in pixels/lines (1..8).
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 VS, HS  in  1 each  sync/valid levels, synchronous to CLK.
REQ-007 CFG_CEN_H, CFG_CEN_V, CFG_SIZE_H, CFG_SIZE_V  in  NW*CW each  per-window centre and size; window i in bits [i*CW +: CW].
REQ-008 CFG_EN  in  NW  per-window enable.
REQ-009 H_CNT, V_CNT  out  CW each  pixel and line counters.
REQ-010 LINE, ACTIV_C  out  NW each  per-window border flag and inside flag.
REQ-011 ACTIV_V  out  1  registered HS & VS.
REQ-012 H_LEN, V_LEN  out  CW each  measured line period (clocks) and frame height (lines).
REQ-013 LOCK  out  1  timing stable.

Function
REQ-014 Edge detect: hs_rise = !rHS & HS, vs_rise = !rVS & VS; rHS/rVS register HS/VS every cycle.
REQ-015 H_CNT: 0 on hs_rise, else +1, saturating at 2^CW-1 (no wrap).
REQ-016 V_CNT: 0 on vs_rise (wins over simultaneous hs_rise), else +1 on hs_rise, saturating at 2^CW-1.
REQ-017 Shadow config: on vs_rise all CFG_* captured into shadow registers; window logic uses shadows only; mid-frame CFG changes have no effect until the next vs_rise.
REQ-018 Bounds per window, computed in CW+1 bits: lo = CEN - (SIZE>>1), clamped to 0 if negative; hi = CEN + (SIZE>>1), clamped to 2^CW-1.
REQ-019 ACTIV_C[i] <= en_i & SIZE_H!=0 & SIZE_V!=0 & hlo<=H_CNT<hhi & vlo<=V_CNT<vhi.
REQ-020 LINE[i] <= en_i & nonzero sizes & hlo<=H_CNT<=hhi & vlo<=V_CNT<=vhi & (H_CNT<hlo+BORDER | H_CNT>hhi-BORDER | V_CNT<vlo+BORDER | V_CNT>vhi-BORDER).
REQ-021 ACTIV_V, LINE, ACTIV_C: one-cycle registered latency relative to the H_CNT/V_CNT values they decode.
REQ-022 On hs_rise, H_LEN <= H_CNT+1, saturating (the HS period in clocks).
REQ-023 On vs_rise, V_LEN <= V_CNT (hs_rise count in the closing frame).
REQ-024 FSM states IDLE, MEAS, LOCKED; LOCK=1 only in LOCKED; refs H_REF/V_REF are internal registers.
REQ-025 IDLE: on vs_rise, load H_REF=H_LEN, V_REF=V_CNT, go to MEAS.
REQ-026 MEAS: on vs_rise, if V_CNT==V_REF and H_LEN==H_REF go to LOCKED, else reload refs and stay.
REQ-027 LOCKED: on vs_rise with mismatch, reload refs and go to MEAS.
REQ-028 Any state: H_CNT or V_CNT at saturation value forces IDLE next cycle (loss of sync); this has priority over REQ-025..027.

Reset
REQ-029 While RESET=1: H_CNT, V_CNT, H_LEN, V_LEN, LINE, ACTIV_C, ACTIV_V, LOCK = 0; shadows and refs = 0; FSM = IDLE.
REQ-030 rHS and rVS reset to 1, so HS/VS already high at reset release are not edges.
REQ-031 Reset release mid-frame: counting restarts from 0; no edge recognised until HS/VS go low then high.

Verification
REQ-032 RESET released with HS=VS=1 held -> H_CNT counts 0,1,2...; V_CNT=0; LOCK=0; no hs_rise/vs_rise.
REQ-033 HS period 800 clocks, 525 lines/frame -> H_LEN=800, V_LEN=525; LOCK=1 the cycle after the third vs_rise.
REQ-034 Window0 CEN 450/250, SIZE 200/200, EN=1, BORDER=1 -> ACTIV_C[0] for H 350..549, V 150..349; LINE[0] on V=150 or 350 for H 350..550, and on H=350 or 550 for V 150..350; window1 EN=0 -> flags stay 0.
REQ-035 CFG_CEN_H changed at V_CNT=100 -> outputs unchanged for the rest of the frame; new box from the next frame.
REQ-036 CEN_H=10, SIZE_H=100 -> hlo=0, hhi=60; SIZE_V=0 -> ACTIV_C and LINE stay 0.
REQ-037 HS held low after LOCK -> H_CNT saturates at 4095 and stays; LOCK=0 the next cycle; FSM IDLE.

Source files
------------

// File: rtl/lcd_counter_roi.sv
// lcd_counter_roi
// Video timing counters with per-window region-of-interest overlay.
// HS/VS rising edges drive a pixel counter (H_CNT) and a line counter
// (V_CNT). The HS period and the frame height are measured every frame,
// and a small state machine raises LOCK once two consecutive frames agree.
// NW overlay windows are described by centre and size. Their settings are
// sampled into shadow registers on each VS rising edge, so a frame always
// uses one consistent set of boxes. Each window yields an "inside" flag
// (ACTIV_C) and a border flag (LINE).
module lcd_counter_roi #(
    parameter int CW     = 12,
    parameter int NW     = 2,
    parameter int BORDER = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VS,
    input  logic             HS,
    input  logic [NW*CW-1:0] CFG_CEN_H,
    input  logic [NW*CW-1:0] CFG_CEN_V,
    input  logic [NW*CW-1:0] CFG_SIZE_H,
    input  logic [NW*CW-1:0] CFG_SIZE_V,
    input  logic [NW-1:0]    CFG_EN,
    output logic [CW-1:0]    H_CNT,
    output logic [CW-1:0]    V_CNT,
    output logic [NW-1:0]    LINE,
    output logic [NW-1:0]    ACTIV_C,
    output logic             ACTIV_V,
    output logic [CW-1:0]    H_LEN,
    output logic [CW-1:0]    V_LEN,
    output logic             LOCK
);

    // Saturation value of every counter. The same value, widened by one
    // bit, is used when window bounds are worked out without overflow.
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   MAX_W   = {1'b0, CNT_MAX};
    localparam logic [CW:0]   BRD_W   = (CW+1)'(BORDER);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic hs_reg;
    logic vs_reg;
    logic hs_rise;
    logic vs_rise;
    logic h_at_max;
    logic v_at_max;

    logic [NW*CW-1:0] sh_cen_h;
    logic [NW*CW-1:0] sh_cen_v;
    logic [NW*CW-1:0] sh_size_h;
    logic [NW*CW-1:0] sh_size_v;
    logic [NW-1:0]    sh_en;

    logic [NW-1:0] activ_c_next;
    logic [NW-1:0] line_next;

    state_t        state;
    logic [CW-1:0] h_ref;
    logic [CW-1:0] v_ref;

    // The sync registers reset high. A level that is already high when
    // reset is released therefore does not count as an edge.
    assign hs_rise  = ~hs_reg & HS;
    assign vs_rise  = ~vs_reg & VS;
    assign h_at_max = (H_CNT == CNT_MAX);
    assign v_at_max = (V_CNT == CNT_MAX);

    // Delayed copies of HS/VS for edge detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hs_reg <= 1'b1;
            vs_reg <= 1'b1;
        end else begin
            hs_reg <= HS;
            vs_reg <= VS;
        end
    end

    // Pixel counter: cleared by each HS edge, otherwise counts and saturates
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            H_CNT <= '0;
        end else if (hs_rise) begin
            H_CNT <= '0;
        end else if (!h_at_max) begin
            H_CNT <= H_CNT + 1'b1;
        end
    end

    // Line counter: a VS edge clears it, even when an HS edge arrives in
    // the same cycle. Otherwise each HS edge advances it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            V_CNT <= '0;
        end else if (vs_rise) begin
            V_CNT <= '0;
        end else if (hs_rise && !v_at_max) begin
            V_CNT <= V_CNT + 1'b1;
        end
    end

    // Period measurements. H_LEN holds the clocks per HS period.
    // V_LEN holds the HS edges seen in the frame that just closed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            H_LEN <= '0;
            V_LEN <= '0;
        end else begin
            if (hs_rise) begin
                H_LEN <= h_at_max ? CNT_MAX : H_CNT + 1'b1;
            end
            if (vs_rise) begin
                V_LEN <= V_CNT;
            end
        end
    end

    // Window settings are frozen at the start of each frame
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sh_cen_h  <= '0;
            sh_cen_v  <= '0;
            sh_size_h <= '0;
            sh_size_v <= '0;
            sh_en     <= '0;
        end else if (vs_rise) begin
            sh_cen_h  <= CFG_CEN_H;
            sh_cen_v  <= CFG_CEN_V;
            sh_size_h <= CFG_SIZE_H;
            sh_size_v <= CFG_SIZE_V;
            sh_en     <= CFG_EN;
        end
    end

    // Per-window bound computation and flag decode. All comparisons use
    // CW+1 bits. This keeps lo+BORDER and H_CNT+BORDER from wrapping, and
    // hi-BORDER never has to be formed.
    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_win
            logic [CW-1:0] cen_h;
            logic [CW-1:0] cen_v;
            logic [CW-1:0] size_h;
            logic [CW-1:0] size_v;
            logic [CW:0]   half_h;
            logic [CW:0]   half_v;
            logic [CW:0]   sum_h;
            logic [CW:0]   sum_v;
            logic [CW:0]   hlo;
            logic [CW:0]   hhi;
            logic [CW:0]   vlo;
            logic [CW:0]   vhi;
            logic [CW:0]   h_w;
            logic [CW:0]   v_w;
            logic          valid;
            logic          in_fill;
            logic          in_outer;
            logic          on_edge;

            assign cen_h  = sh_cen_h[gi*CW +: CW];
            assign cen_v  = sh_cen_v[gi*CW +: CW];
            assign size_h = sh_size_h[gi*CW +: CW];
            assign size_v = sh_size_v[gi*CW +: CW];

            assign half_h = {2'b00, size_h[CW-1:1]};
            assign half_v = {2'b00, size_v[CW-1:1]};
            assign sum_h  = {1'b0, cen_h} + half_h;
            assign sum_v  = {1'b0, cen_v} + half_v;

            // The lower bound clamps to zero. The upper bound clamps to the
            // counter maximum.
            assign hlo = ({1'b0, cen_h} < half_h) ? '0 : {1'b0, cen_h} - half_h;
            assign vlo = ({1'b0, cen_v} < half_v) ? '0 : {1'b0, cen_v} - half_v;
            assign hhi = (sum_h > MAX_W) ? MAX_W : sum_h;
            assign vhi = (sum_v > MAX_W) ? MAX_W : sum_v;

            assign h_w = {1'b0, H_CNT};
            assign v_w = {1'b0, V_CNT};

            // A window with zero width or zero height draws nothing
            assign valid = sh_en[gi] && (size_h != '0) && (size_v != '0);

            // Fill area is half-open [lo, hi). The outline uses the closed
            // box [lo, hi], so the border includes the hi column and row.
            assign in_fill  = (h_w >= hlo) && (h_w < hhi) &&
                              (v_w >= vlo) && (v_w < vhi);
            assign in_outer = (h_w >= hlo) && (h_w <= hhi) &&
                              (v_w >= vlo) && (v_w <= vhi);
            assign on_edge  = (h_w < hlo + BRD_W) || (h_w + BRD_W > hhi) ||
                              (v_w < vlo + BRD_W) || (v_w + BRD_W > vhi);

            assign activ_c_next[gi] = valid && in_fill;
            assign line_next[gi]    = valid && in_outer && on_edge;
        end
    endgenerate

    // Overlay outputs, one clock behind the counters they decode
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ACTIV_C <= '0;
            LINE    <= '0;
            ACTIV_V <= 1'b0;
        end else begin
            ACTIV_C <= activ_c_next;
            LINE    <= line_next;
            ACTIV_V <= HS & VS;
        end
    end

    // Lock tracker. Each frame's H_LEN and line count are compared with
    // the previous frame's. A saturated counter means sync was lost, and
    // that overrides everything else.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            h_ref <= '0;
            v_ref <= '0;
            LOCK  <= 1'b0;
        end else if (h_at_max || v_at_max) begin
            state <= IDLE;
            LOCK  <= 1'b0;
        end else if (vs_rise) begin
            case (state)
                IDLE: begin
                    h_ref <= H_LEN;
                    v_ref <= V_CNT;
                    state <= MEAS;
                    LOCK  <= 1'b0;
                end
                MEAS, LOCKED: begin
                    if ((V_CNT == v_ref) && (H_LEN == h_ref)) begin
                        state <= LOCKED;
                        LOCK  <= 1'b1;
                    end else begin
                        h_ref <= H_LEN;
                        v_ref <= V_CNT;
                        state <= MEAS;
                        LOCK  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    LOCK  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_counter_roi.sv
// tb_lcd_counter_roi
// Randomized bench for lcd_counter_roi. A raster generator with short
// lines drives HS/VS, and the window settings are randomized, including
// changes in the middle of a frame. A behavioural model in plain integer
// arithmetic predicts every output. Directed checks cover reset, free-run,
// lock, reset mid-frame and loss-of-sync saturation.
module tb_lcd_counter_roi;

    localparam int CW     = 12;
    localparam int NW     = 2;
    localparam int BORDER = 1;
    localparam int MAXV   = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             vs;
    logic             hs;
    logic [NW*CW-1:0] cfg_cen_h;
    logic [NW*CW-1:0] cfg_cen_v;
    logic [NW*CW-1:0] cfg_size_h;
    logic [NW*CW-1:0] cfg_size_v;
    logic [NW-1:0]    cfg_en;
    logic [CW-1:0]    h_cnt;
    logic [CW-1:0]    v_cnt;
    logic [NW-1:0]    line;
    logic [NW-1:0]    activ_c;
    logic             activ_v;
    logic [CW-1:0]    h_len;
    logic [CW-1:0]    v_len;
    logic             lock;

    int n_checks = 0;
    int n_fails  = 0;

    lcd_counter_roi #(.CW(CW), .NW(NW), .BORDER(BORDER)) dut (
        .CLK(clk),
        .RESET(rst),
        .VS(vs),
        .HS(hs),
        .CFG_CEN_H(cfg_cen_h),
        .CFG_CEN_V(cfg_cen_v),
        .CFG_SIZE_H(cfg_size_h),
        .CFG_SIZE_V(cfg_size_v),
        .CFG_EN(cfg_en),
        .H_CNT(h_cnt),
        .V_CNT(v_cnt),
        .LINE(line),
        .ACTIV_C(activ_c),
        .ACTIV_V(activ_v),
        .H_LEN(h_len),
        .V_LEN(v_len),
        .LOCK(lock)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_phs, m_pvs, m_h, m_v, m_hlen, m_vlen, m_av, m_lock;
    int m_state;                    // 0 idle, 1 measuring, 2 locked
    int m_href, m_vref;
    int m_ac [NW];
    int m_ln [NW];
    int sh_ch [NW];
    int sh_cv [NW];
    int sh_sh [NW];
    int sh_sv [NW];
    int sh_en [NW];
    int t_hr, t_vr, t_a, t_l;

    function automatic void win_flags(input int i, input int h, input int v,
                                      output int act, output int ln);
        int hlo, hhi, vlo, vhi, ok;
        hlo = sh_ch[i] - sh_sh[i] / 2; if (hlo < 0) hlo = 0;
        hhi = sh_ch[i] + sh_sh[i] / 2; if (hhi > MAXV) hhi = MAXV;
        vlo = sh_cv[i] - sh_sv[i] / 2; if (vlo < 0) vlo = 0;
        vhi = sh_cv[i] + sh_sv[i] / 2; if (vhi > MAXV) vhi = MAXV;
        ok  = (sh_en[i] != 0 && sh_sh[i] != 0 && sh_sv[i] != 0) ? 1 : 0;
        act = (ok != 0 && h >= hlo && h < hhi && v >= vlo && v < vhi) ? 1 : 0;
        ln  = (ok != 0 && h >= hlo && h <= hhi && v >= vlo && v <= vhi &&
               (h < hlo + BORDER || h > hhi - BORDER ||
                v < vlo + BORDER || v > vhi - BORDER)) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phs = 1; m_pvs = 1; m_h = 0; m_v = 0; m_hlen = 0; m_vlen = 0;
            m_av = 0; m_lock = 0; m_state = 0; m_href = 0; m_vref = 0;
            for (int i = 0; i < NW; i++) begin
                m_ac[i] = 0; m_ln[i] = 0;
                sh_ch[i] = 0; sh_cv[i] = 0; sh_sh[i] = 0; sh_sv[i] = 0; sh_en[i] = 0;
            end
        end else begin
            t_hr = (m_phs == 0 && hs) ? 1 : 0;
            t_vr = (m_pvs == 0 && vs) ? 1 : 0;
            // overlay flags from the counts before this edge
            for (int i = 0; i < NW; i++) begin
                win_flags(i, m_h, m_v, t_a, t_l);
                m_ac[i] = t_a; m_ln[i] = t_l;
            end
            m_av = (hs && vs) ? 1 : 0;
            // lock tracking
            if (m_h == MAXV || m_v == MAXV) begin
                m_state = 0;
            end else if (t_vr != 0) begin
                if (m_state != 0 && m_v == m_vref && m_hlen == m_href) begin
                    m_state = 2;
                end else begin
                    m_href = m_hlen; m_vref = m_v; m_state = 1;
                end
            end
            m_lock = (m_state == 2) ? 1 : 0;
            // measurements
            if (t_hr != 0) m_hlen = (m_h + 1 > MAXV) ? MAXV : m_h + 1;
            if (t_vr != 0) m_vlen = m_v;
            // frame-start capture of window settings
            if (t_vr != 0) begin
                for (int i = 0; i < NW; i++) begin
                    sh_ch[i] = int'(cfg_cen_h[i*CW +: CW]);
                    sh_cv[i] = int'(cfg_cen_v[i*CW +: CW]);
                    sh_sh[i] = int'(cfg_size_h[i*CW +: CW]);
                    sh_sv[i] = int'(cfg_size_v[i*CW +: CW]);
                    sh_en[i] = cfg_en[i] ? 1 : 0;
                end
            end
            // counters
            if (t_vr != 0)      m_v = 0;
            else if (t_hr != 0) m_v = (m_v + 1 > MAXV) ? MAXV : m_v + 1;
            if (t_hr != 0) m_h = 0;
            else           m_h = (m_h + 1 > MAXV) ? MAXV : m_h + 1;
            m_phs = hs ? 1 : 0;
            m_pvs = vs ? 1 : 0;
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check_eq("h_cnt", int'(h_cnt), m_h);
        check_eq("v_cnt", int'(v_cnt), m_v);
        check_eq("h_len", int'(h_len), m_hlen);
        check_eq("v_len", int'(v_len), m_vlen);
        check_eq("lock", int'(lock), m_lock);
        check_eq("activ_v", int'(activ_v), m_av);
        for (int i = 0; i < NW; i++) begin
            check_eq($sformatf("activ_c%0d", i), int'(activ_c[i]), m_ac[i]);
            check_eq($sformatf("line%0d", i), int'(line[i]), m_ln[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    int hp = 64, hb = 8, nl = 24, vb = 3;
    int gx = 0, gy = 0;

    task automatic rand_cfg();
        int ch, cv, sz_h, sz_v, pick;
        for (int i = 0; i < NW; i++) begin
            pick = int'($urandom_range(0, 11));
            ch   = int'($urandom_range(0, hp + 8));
            sz_h = int'($urandom_range(1, 70));
            cv   = int'($urandom_range(0, nl + 4));
            sz_v = int'($urandom_range(1, 24));
            if (pick == 0) begin ch = 10; sz_h = 100; end          // clamps low
            if (pick == 1) begin ch = 4000; sz_h = 400; end        // clamps high
            if (pick == 2) sz_h = 0;
            if (pick == 3) sz_v = 0;
            cfg_cen_h[i*CW +: CW]  = CW'(ch);
            cfg_size_h[i*CW +: CW] = CW'(sz_h);
            cfg_cen_v[i*CW +: CW]  = CW'(cv);
            cfg_size_v[i*CW +: CW] = CW'(sz_v);
            cfg_en[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // One clock: compare, then drive the next raster position
    task automatic step();
        int pos;
        @(negedge clk);
        compare_all();
        pos = gy * hp + gx;
        hs = (gx < hp - hb);
        vs = (pos >= vb * hp + hp / 2);
        if ($urandom_range(0, 299) == 0) rand_cfg();   // change in mid-frame
        gx++;
        if (gx == hp) begin
            gx = 0;
            gy++;
            if (gy >= nl) begin
                gy = 0;
                if ($urandom_range(0, 1) == 0) rand_cfg();
            end
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n * hp * nl) step();
    endtask

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1;
        cfg_cen_h = '0; cfg_cen_v = '0; cfg_size_h = '0; cfg_size_v = '0; cfg_en = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_h_cnt", int'(h_cnt), 0);
        check_eq("rst_v_cnt", int'(v_cnt), 0);
        check_eq("rst_lock", int'(lock), 0);
        check_eq("rst_h_len", int'(h_len), 0);
        check_eq("rst_v_len", int'(v_len), 0);
        check_eq("rst_flags", int'({line, activ_c, activ_v}), 0);
        rst = 1'b0;

        // HS/VS held high through release: free-running pixel count only
        repeat (10) begin
            @(negedge clk);
            compare_all();
        end
        check_eq("hold_h_cnt", int'(h_cnt), 10);
        check_eq("hold_v_cnt", int'(v_cnt), 0);
        check_eq("hold_lock", int'(lock), 0);

        // Stable raster: measure and lock
        rand_cfg();
        gx = 0; gy = 0;
        run_frames(6);
        check_eq("meas_h_len", int'(h_len), 64);
        check_eq("meas_v_len", int'(v_len), 24);
        check_eq("locked", int'(lock), 1);

        // Frame height change: lock drops, then comes back
        nl = 26;
        run_frames(4);
        check_eq("meas_v_len26", int'(v_len), 26);
        check_eq("relocked", int'(lock), 1);

        // Reset pulse in the middle of a frame
        repeat (hp * nl / 2) step();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        repeat (hp * nl / 2) step();
        run_frames(4);
        check_eq("lock_after_rst", int'(lock), 1);

        // HS stuck low: pixel counter saturates, lock is lost
        repeat (MAXV + 100) begin
            @(negedge clk);
            compare_all();
            hs = 1'b0;
            vs = 1'b0;
        end
        check_eq("sat_h_cnt", int'(h_cnt), MAXV);
        check_eq("sat_lock", int'(lock), 0);

        // Recovery
        gx = 0; gy = 0; nl = 24;
        run_frames(4);
        check_eq("recover_lock", int'(lock), 1);
        check_eq("recover_h_len", int'(h_len), 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
